// File: rtl/equiv_mismatch_monitor_pkg.sv
// equiv_mon_pkg: shared types and constants for the equivalence mismatch monitor.
package equiv_mon_pkg;

  // Monitor FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_COMPARE = 2'd2,
    ST_REPORT  = 2'd3
  } state_e;

  localparam int unsigned MISMATCH_CNT_W = 16;
  localparam logic [MISMATCH_CNT_W-1:0] MISMATCH_CNT_SAT = 16'hFFFF;

  // Bits needed to index 0..n-1, never less than 1
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/equiv_mismatch_monitor_if.sv
// equiv_mon_if: compared buses, run control and summary handshake of the monitor.
// master = harness/consumer side, slave = monitor side.
interface equiv_mon_if #(
  parameter int unsigned W     = 91,
  parameter int unsigned CNT_W = 10
);
  logic             start;
  logic [W-1:0]     y_1;
  logic [W-1:0]     y_2;
  logic             busy;
  logic             report_valid;
  logic             report_ready;
  logic             pass;
  logic [15:0]      mismatch_cnt;
  logic [CNT_W-1:0] first_idx;
  logic [W-1:0]     first_diff;

  modport master (
    output start, y_1, y_2, report_ready,
    input  busy, report_valid, pass, mismatch_cnt, first_idx, first_diff
  );

  modport slave (
    input  start, y_1, y_2, report_ready,
    output busy, report_valid, pass, mismatch_cnt, first_idx, first_diff
  );
endinterface

// File: rtl/equiv_sat_counter.sv
// equiv_sat_counter: saturating incrementer with synchronous clear.
module equiv_sat_counter #(
  parameter int unsigned   CW      = 16,
  parameter logic [CW-1:0] SAT_VAL = '1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [CW-1:0] o_cnt
);

  logic [CW-1:0] r_cnt;

  // Clear wins over increment; hold once the saturation value is reached
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != SAT_VAL)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/equiv_mismatch_monitor.sv
// equiv_mismatch_monitor: warm-up, windowed y_1/y_2 comparison, first-mismatch
// capture and a single valid/ready summary per run.
// Optional build macro EQUIV_MON_STOP_ON_FAIL_EN: the first mismatch ends the window.
module equiv_mismatch_monitor
  import equiv_mon_pkg::*;
#(
  parameter int unsigned W      = 91,
  parameter int unsigned WARMUP = 4,
  parameter int unsigned WINDOW = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  equiv_mon_if.slave  bus
);

  localparam int unsigned CNT_W       = cnt_width(WINDOW);
  localparam int unsigned PH_MAX      = (WARMUP > WINDOW) ? WARMUP : WINDOW;
  localparam int unsigned PH_W        = cnt_width(PH_MAX);
  localparam int unsigned WARMUP_LAST = (WARMUP > 0) ? WARMUP - 1 : 0;
  localparam int unsigned WINDOW_LAST = (WINDOW > 0) ? WINDOW - 1 : 0;

  state_e                    r_state;
  logic [PH_W-1:0]           r_phase;
  logic                      r_seen;
  logic                      r_busy;
  logic                      r_valid;
  logic                      r_pass;
  logic [CNT_W-1:0]          r_first_idx;
  logic [W-1:0]              r_first_diff;

  logic [W-1:0]              w_diff;
  logic                      w_mismatch;
  logic                      w_last;
  logic                      w_end;
  logic                      w_cnt_clr;
  logic                      w_cnt_inc;
  logic [MISMATCH_CNT_W-1:0] w_cnt;

  assign w_diff     = bus.y_1 ^ bus.y_2;
  assign w_mismatch = |w_diff;
  assign w_last     = (r_phase == PH_W'(WINDOW_LAST));

`ifdef EQUIV_MON_STOP_ON_FAIL_EN
  assign w_end = w_last || w_mismatch;
`else
  assign w_end = w_last;
`endif

  assign w_cnt_clr = (r_state == ST_IDLE) && bus.start;
  assign w_cnt_inc = (r_state == ST_COMPARE) && w_mismatch;

  equiv_sat_counter #(
    .CW      (MISMATCH_CNT_W),
    .SAT_VAL (MISMATCH_CNT_SAT)
  ) u_mismatch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_cnt_clr),
    .i_inc (w_cnt_inc),
    .o_cnt (w_cnt)
  );

  // Run FSM with phase counter, first-mismatch capture and registered status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_phase      <= '0;
      r_seen       <= 1'b0;
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
      r_pass       <= 1'b1;
      r_first_idx  <= '0;
      r_first_diff <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_phase      <= '0;
            r_seen       <= 1'b0;
            r_pass       <= 1'b1;
            r_first_idx  <= '0;
            r_first_diff <= '0;
            r_busy       <= 1'b1;
            r_state      <= (WARMUP == 0) ? ST_COMPARE : ST_WARMUP;
          end
        end
        ST_WARMUP: begin
          if (r_phase == PH_W'(WARMUP_LAST)) begin
            r_phase <= '0;
            r_state <= ST_COMPARE;
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end
        ST_COMPARE: begin
          if (w_mismatch) begin
            r_pass <= 1'b0;
            if (!r_seen) begin
              r_seen       <= 1'b1;
              r_first_idx  <= CNT_W'(r_phase);
              r_first_diff <= w_diff;
            end
          end
          if (w_end) begin
            r_state <= ST_REPORT;
            r_valid <= 1'b1;
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end
        ST_REPORT: begin
          if (bus.report_ready) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.report_valid = r_valid;
  assign bus.pass         = r_pass;
  assign bus.mismatch_cnt = w_cnt;
  assign bus.first_idx    = r_first_idx;
  assign bus.first_diff   = r_first_diff;

endmodule

// File: tb/tb_equiv_mismatch_monitor.sv
// tb_equiv_mismatch_monitor: table-driven runs with a scoreboard of expected
// summaries, plus report-hold, mid-run reset and reset-with-start sequences.
module tb_equiv_mismatch_monitor;

  localparam int unsigned W      = 91;
  localparam int unsigned WARMUP = 4;
  localparam int unsigned WINDOW = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int          LAT    = WARMUP + WINDOW + 1;
  localparam int          BOUND  = 200;

  typedef struct {
    logic             pass;
    logic [15:0]      cnt;
    logic [CNT_W-1:0] fi;
    logic [W-1:0]     fd;
  } exp_t;

  typedef struct {
    logic [15:0] mask;
    int          bitpos;
    bit          warm_dirty;
    exp_t        exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_fail;
  exp_t sb_q[$];
  vec_t vecs[6];

  equiv_mon_if #(.W(W), .CNT_W(CNT_W)) bus ();

  equiv_mismatch_monitor #(
    .W      (W),
    .WARMUP (WARMUP),
    .WINDOW (WINDOW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_bus();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return W'(r);
  endfunction

  // Drive the sample seen at edge number e of a run (edge 1 samples start)
  task automatic apply(input vec_t v, input int e);
    logic [W-1:0] a;
    logic [W-1:0] b;
    int k;
    a = rand_bus();
    b = a;
    if (e >= 2 && e <= 1 + WARMUP && v.warm_dirty) b = a ^ W'(1);
    k = e - 2 - WARMUP;
    if (k >= 0 && k < WINDOW && v.mask[k]) b = a ^ (W'(1) << v.bitpos);
    bus.y_1 = a;
    bus.y_2 = b;
  endtask

  // Start a run, wait for report_valid, compare against the scoreboard head
  task automatic drive_run(input vec_t v, input string tag);
    int   lat;
    exp_t e;
    sb_q.push_back(v.exp);
    @(negedge clk);
    bus.start = 1'b1;
    apply(v, 1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, ".busy"}, 128'(bus.busy), 128'(1));
    while (!bus.report_valid && lat < BOUND) begin
      apply(v, lat + 1);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    e = sb_q.pop_front();
    check({tag, ".latency"}, 128'(lat), 128'(LAT));
    check({tag, ".valid"}, 128'(bus.report_valid), 128'(1));
    check({tag, ".pass"}, 128'(bus.pass), 128'(e.pass));
    check({tag, ".cnt"}, 128'(bus.mismatch_cnt), 128'(e.cnt));
    check({tag, ".first_idx"}, 128'(bus.first_idx), 128'(e.fi));
    check({tag, ".first_diff"}, 128'(bus.first_diff), 128'(e.fd));
  endtask

  task automatic handshake(input string tag);
    bus.report_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.report_ready = 1'b0;
    check({tag, ".valid_low"}, 128'(bus.report_valid), 128'(0));
    check({tag, ".busy_low"}, 128'(bus.busy), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] one;
    vec_t rv;
    int   lat;
    n_vec  = 0;
    n_fail = 0;
    one    = W'(1);

    vecs[0] = '{mask: 16'h0000, bitpos: 0,  warm_dirty: 1'b0,
                exp: '{pass: 1'b1, cnt: 16'd0,  fi: 4'd0,  fd: '0}};
    vecs[1] = '{mask: 16'h0208, bitpos: 90, warm_dirty: 1'b0,
                exp: '{pass: 1'b0, cnt: 16'd2,  fi: 4'd3,  fd: one << 90}};
    vecs[2] = '{mask: 16'h0000, bitpos: 0,  warm_dirty: 1'b1,
                exp: '{pass: 1'b1, cnt: 16'd0,  fi: 4'd0,  fd: '0}};
    vecs[3] = '{mask: 16'h8000, bitpos: 0,  warm_dirty: 1'b0,
                exp: '{pass: 1'b0, cnt: 16'd1,  fi: 4'd15, fd: one}};
    vecs[4] = '{mask: 16'hFFFF, bitpos: 7,  warm_dirty: 1'b1,
                exp: '{pass: 1'b0, cnt: 16'd16, fi: 4'd0,  fd: one << 7}};
    vecs[5] = '{mask: 16'h4001, bitpos: 45, warm_dirty: 1'b0,
                exp: '{pass: 1'b0, cnt: 16'd2,  fi: 4'd0,  fd: one << 45}};

    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.report_ready = 1'b0;
    bus.y_1          = '0;
    bus.y_2          = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.busy", 128'(bus.busy), 128'(0));
    check("reset.valid", 128'(bus.report_valid), 128'(0));
    check("reset.pass", 128'(bus.pass), 128'(1));
    check("reset.cnt", 128'(bus.mismatch_cnt), 128'(0));
    check("reset.first_idx", 128'(bus.first_idx), 128'(0));
    check("reset.first_diff", 128'(bus.first_diff), 128'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      drive_run(vecs[i], $sformatf("vec%0d", i));
      handshake($sformatf("vec%0d", i));
    end

    // Report held with ready low; start pulses must be ignored
    drive_run(vecs[1], "hold");
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'b1;
      check("hold.valid", 128'(bus.report_valid), 128'(1));
      check("hold.cnt", 128'(bus.mismatch_cnt), 128'(2));
      check("hold.first_idx", 128'(bus.first_idx), 128'(3));
      check("hold.first_diff", 128'(bus.first_diff), 128'(one << 90));
      @(posedge clk);
      @(negedge clk);
    end
    bus.start = 1'b0;
    handshake("hold");
    check("idle.cnt_kept", 128'(bus.mismatch_cnt), 128'(2));
    check("idle.first_idx_kept", 128'(bus.first_idx), 128'(3));
    check("idle.pass_kept", 128'(bus.pass), 128'(0));
    @(posedge clk);
    @(negedge clk);
    check("idle.start_ignored", 128'(bus.busy), 128'(0));

    // Reset at compare index 7 after mismatches at indices 1 and 4
    rv = '{mask: 16'h0012, bitpos: 20, warm_dirty: 1'b0,
           exp: '{pass: 1'b0, cnt: 16'd2, fi: 4'd1, fd: one << 20}};
    @(negedge clk);
    bus.start = 1'b1;
    apply(rv, 1);
    @(posedge clk);
    for (int e = 2; e <= 2 + WARMUP + 6; e++) begin
      @(negedge clk);
      bus.start = 1'b0;
      apply(rv, e);
      @(posedge clk);
    end
    @(negedge clk);
    check("midrun.cnt_before", 128'(bus.mismatch_cnt), 128'(2));
    rst_n = 1'b0;
    apply(rv, 2 + WARMUP + 7);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrun.busy", 128'(bus.busy), 128'(0));
    check("midrun.cnt", 128'(bus.mismatch_cnt), 128'(0));
    check("midrun.valid", 128'(bus.report_valid), 128'(0));
    check("midrun.pass", 128'(bus.pass), 128'(1));
    check("midrun.first_idx", 128'(bus.first_idx), 128'(0));
    drive_run(vecs[3], "after_reset");
    handshake("after_reset");

    // Reset released while start is already high
    @(negedge clk);
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.y_1   = '0;
    bus.y_2   = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("rst_start.busy", 128'(bus.busy), 128'(1));
    lat = 1;
    while (!bus.report_valid && lat < BOUND) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("rst_start.latency", 128'(lat), 128'(LAT));
    check("rst_start.pass", 128'(bus.pass), 128'(1));
    handshake("rst_start");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/equiv_mismatch_monitor.md
# equiv_mismatch_monitor

Downstream consumer of the equivalence harness outputs: samples the two 91-bit result buses `y_1`/`y_2` every cycle over a bounded comparison window and reports pass/fail. It runs a warm-up phase to skip uninitialised register state, then counts mismatches and captures the first one. A single summary is handed off over a valid/ready handshake. It replaces the bare per-cycle assertion with a countable, reportable result for fuzz-campaign logging.

## Interface
- `W`, 91: width of each compared bus.
- `WARMUP`, 4: cycles ignored after `start` before comparison begins; 0 is legal.
- `WINDOW`, 1024: number of compared cycles; at least 1.
- `clk`  in  1  clock; all logic on its rising edge.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `start`  in  1  begin a run; honoured only in IDLE.
- `y_1`  in  W  result of implementation 1.
- `y_2`  in  W  result of implementation 2.
- `busy`  out  1  high in WARMUP, COMPARE and REPORT.
- `report_valid`  out  1  summary available.
- `report_ready`  in  1  consumer accepts the summary.
- `pass`  out  1  1 iff `mismatch_cnt` is 0; valid while `report_valid` is high.
- `mismatch_cnt`  out  16  number of mismatching compared cycles; saturates at 0xFFFF.
- `first_idx`  out  CNT_W  compare-phase index (0-based) of the first mismatch; 0 if none.
- `first_diff`  out  W  `y_1 ^ y_2` at the first mismatch; 0 if none.

## Operation
- The FSM has four states: IDLE, WARMUP, COMPARE and REPORT.
- IDLE -> WARMUP when `start`=1. If `WARMUP`=0, the transition is IDLE -> COMPARE instead.
- On leaving IDLE, the block clears `mismatch_cnt`, `first_idx`, `first_diff` and the phase counter.
- WARMUP lasts exactly `WARMUP` cycles, then moves to COMPARE. The buses are not examined during WARMUP.
- COMPARE lasts exactly `WINDOW` cycles, with indices 0..WINDOW-1. Each cycle, a mismatch is flagged when `y_1 != y_2`.
- On a mismatch cycle:
  - `mismatch_cnt` increments, saturating.
  - If this is the first mismatch of the run, the block latches `first_idx` = current index and `first_diff` = XOR.
- After index WINDOW-1 is compared, the FSM moves to REPORT.
- REPORT:
  - `report_valid`=1.
  - All summary outputs are held stable.
  - When `report_valid` && `report_ready` on an edge, the FSM returns to IDLE.
- `start` is ignored outside IDLE.
- Summary outputs keep their last values in IDLE until the next `start`.
- Arithmetic and width rules:
  - Comparison is bitwise over all W bits.
  - X/Z handling is not the block's concern; synthesis semantics apply.
  - CNT_W = clog2(WINDOW), minimum 1.

## Timing
- Reset values:
  - State is IDLE.
  - `busy`=0, `report_valid`=0.
  - `pass`=1, `mismatch_cnt`=0, `first_idx`=0, `first_diff`=0.
- `start` sampled at edge t: `busy`=1 from t+1.
- The first compared sample is the value of `y_*` at edge t+1+WARMUP.
- The last compared sample is at edge t+WARMUP+WINDOW.
- `report_valid` rises in the cycle after the last compare; total latency from `start` to `report_valid` is WARMUP+WINDOW+1 cycles.
- `report_ready` may be high before `report_valid`; the handshake then completes on the first REPORT edge, giving a 1-cycle REPORT.
- A mismatch on the last compared cycle is counted and included in the report.
- Reset asserted mid-run: on the next edge the block returns to reset values and any partial summary is discarded.
- Reset deasserted with `start` already high: `start` is honoured on the first edge with `rst_n`=1.

## Configuration
- Macro: `EQUIV_MON_STOP_ON_FAIL_EN`.
- Defined: the first mismatch in COMPARE ends the window. The FSM goes to REPORT on the next edge with `mismatch_cnt`=1.
- Undefined: the full WINDOW is always compared.

## Structure
- Package `equiv_mon_pkg` holds:
  - the state enum (IDLE, WARMUP, COMPARE, REPORT);
  - `MISMATCH_CNT_W`=16;
  - the saturation constant.
- One sub-module, `equiv_sat_counter`: a parameterised-width saturating incrementer with synchronous clear. It is instantiated once for `mismatch_cnt`.
- Phase counter, FSM and capture registers live in the top of the block.

## Test plan
- WARMUP=4, WINDOW=16, `y_1`=`y_2` throughout -> `report_valid` 21 cycles after `start`; `pass`=1, cnt=0, `first_idx`=0, `first_diff`=0.
- Buses differ only in bit 90 at compare indices 3 and 9 -> cnt=2, `first_idx`=3, `first_diff`=1<<90, `pass`=0.
- Buses differ during WARMUP only -> `pass`=1. Buses differ at index 15 (last) only -> cnt=1, `first_idx`=15.
- Hold `report_ready`=0 for 5 cycles in REPORT -> outputs stable and `report_valid` held. A second `start` during that time is ignored. Raise `report_ready` -> IDLE next edge.
- `rst_n`=0 at compare index 7 after 2 mismatches -> next edge: IDLE, cnt=0, `busy`=0. A fresh `start` then yields an independent result.
- With `EQUIV_MON_STOP_ON_FAIL_EN`, WINDOW=1024, mismatch at index 5 -> REPORT at index-5 edge +1, cnt=1, `first_idx`=5.
